// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// alu_multicycle : handshaked ALU, iterative mult/div, Hi/Lo registers
// Optional divider: define ALU_MULTICYCLE_DIV_EN.   Rev 1.0
// ============================================================================
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [4:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   ShiftAmount,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             DivZero,
   output logic             IllegalOp,
   output logic [WIDTH-1:0] HiResult,
   output logic [WIDTH-1:0] LoResult
);

   localparam int CW = $clog2(WIDTH);
   localparam int HB = (WIDTH >= 16) ? 16 : WIDTH;

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SUB   = 5'b00001;
   localparam logic [4:0] OP_MULT  = 5'b00010;
   localparam logic [4:0] OP_AND   = 5'b00011;
   localparam logic [4:0] OP_OR    = 5'b00100;
   localparam logic [4:0] OP_XOR   = 5'b00101;
   localparam logic [4:0] OP_NOR   = 5'b00110;
   localparam logic [4:0] OP_SLL   = 5'b00111;
   localparam logic [4:0] OP_SRL   = 5'b01000;
   localparam logic [4:0] OP_ROTR  = 5'b01001;
   localparam logic [4:0] OP_SRA   = 5'b01010;
   localparam logic [4:0] OP_SEH   = 5'b01011;
   localparam logic [4:0] OP_ADDU  = 5'b01100;
   localparam logic [4:0] OP_MULTU = 5'b01101;
   localparam logic [4:0] OP_SLT   = 5'b01110;
   localparam logic [4:0] OP_SEB   = 5'b01111;
   localparam logic [4:0] OP_SLTU  = 5'b10000;
   localparam logic [4:0] OP_SLLV  = 5'b10001;
   localparam logic [4:0] OP_SRLV  = 5'b10010;
   localparam logic [4:0] OP_SRAV  = 5'b10011;
   localparam logic [4:0] OP_ROTRV = 5'b10100;
   localparam logic [4:0] OP_MOVE  = 5'b10101;
`ifdef ALU_MULTICYCLE_DIV_EN
   localparam logic [4:0] OP_DIV   = 5'b10110;
   localparam logic [4:0] OP_DIVU  = 5'b10111;
`endif
   localparam logic [4:0] OP_MFHI  = 5'b11000;
   localparam logic [4:0] OP_MFLO  = 5'b11001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_valid;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_zero;
   logic               r_divzero;
   logic               r_illegal;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_neg_q;

   logic [WIDTH-1:0]   w_single;
   logic               w_legal;
   logic               w_is_mult;
   logic               w_is_div;
   logic               w_signed_op;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic               w_last;
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_fin_hi;
   logic [WIDTH-1:0]   w_fin_lo;

`ifdef ALU_MULTICYCLE_DIV_EN
   logic               r_is_div;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_dvsr;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH:0]     w_dshift;
   logic [WIDTH:0]     w_ddiff;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;
`endif

   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [SHW-1:0] s);
      // A shift by WIDTH yields zero, so amount 0 returns v unchanged.
      return (v >> s) | (v << (32'(WIDTH) - 32'(s)));
   endfunction

   assign InReady   = Rst_n && (r_state == IDLE);
   assign OutValid  = r_valid;
   assign ALUResult = r_result;
   assign Zero      = r_zero;
   assign DivZero   = r_divzero;
   assign IllegalOp = r_illegal;
   assign HiResult  = r_hi;
   assign LoResult  = r_lo;

   always_comb begin
      w_single  = '0;
      w_legal   = 1'b1;
      w_is_mult = 1'b0;
      w_is_div  = 1'b0;
      case (ALUControl)
         OP_ADD, OP_ADDU: w_single = A + B;
         OP_SUB:          w_single = A - B;
         OP_AND:          w_single = A & B;
         OP_OR:           w_single = A | B;
         OP_XOR:          w_single = A ^ B;
         OP_NOR:          w_single = ~(A | B);
         OP_SLL:          w_single = B << ShiftAmount;
         OP_SRL:          w_single = B >> ShiftAmount;
         OP_ROTR:         w_single = rotr(B, ShiftAmount);
         OP_SRA:          w_single = $unsigned($signed(B) >>> ShiftAmount);
         OP_SLLV:         w_single = B << A[SHW-1:0];
         OP_SRLV:         w_single = B >> A[SHW-1:0];
         OP_SRAV:         w_single = $unsigned($signed(B) >>> A[SHW-1:0]);
         OP_ROTRV:        w_single = rotr(B, A[SHW-1:0]);
         OP_SEH: begin
            for (int i = 0; i < WIDTH; i++) w_single[i] = (i < HB) ? B[i] : B[HB-1];
         end
         OP_SEB: begin
            for (int i = 0; i < WIDTH; i++) w_single[i] = (i < 8) ? B[i] : B[7];
         end
         OP_SLT:          w_single = WIDTH'($signed(A) < $signed(B));
         OP_SLTU:         w_single = WIDTH'(A < B);
         OP_MOVE:         w_single = A;
         OP_MFHI:         w_single = r_hi;
         OP_MFLO:         w_single = r_lo;
         OP_MULT, OP_MULTU: w_is_mult = 1'b1;
`ifdef ALU_MULTICYCLE_DIV_EN
         OP_DIV, OP_DIVU:   w_is_div = 1'b1;
`endif
         default:         w_legal = 1'b0;
      endcase
   end

`ifdef ALU_MULTICYCLE_DIV_EN
   assign w_signed_op = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
`else
   assign w_signed_op = (ALUControl == OP_MULT);
`endif

   // Iterations run on magnitudes; signs are reapplied on the final step.
   assign w_mag_a = (w_signed_op && A[WIDTH-1]) ? -A : A;
   assign w_mag_b = (w_signed_op && B[WIDTH-1]) ? -B : B;
   assign w_last  = (r_cnt == CW'(WIDTH-1));

   always_comb begin
      w_madd     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
      w_prod_nxt = {w_madd, r_prod[WIDTH-1:1]};
      w_prod_fix = r_neg_q ? -w_prod_nxt : w_prod_nxt;
   end

`ifdef ALU_MULTICYCLE_DIV_EN
   always_comb begin
      w_dshift = {r_rem, r_quo[WIDTH-1]};
      w_ddiff  = w_dshift - {1'b0, r_dvsr};
      if (!w_ddiff[WIDTH]) begin
         w_rem_nxt = w_ddiff[WIDTH-1:0];
         w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
      end else begin
         w_rem_nxt = w_dshift[WIDTH-1:0];
         w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
      end
   end
`endif

   always_comb begin
      w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod_fix[WIDTH-1:0];
`ifdef ALU_MULTICYCLE_DIV_EN
      if (r_is_div) begin
         w_fin_hi = r_neg_r ? -w_rem_nxt : w_rem_nxt;
         w_fin_lo = r_neg_q ? -w_quo_nxt : w_quo_nxt;
      end
`endif
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state   <= IDLE;
         r_valid   <= 1'b0;
         r_result  <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_zero    <= 1'b1;
         r_divzero <= 1'b0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
         r_mcand   <= '0;
         r_prod    <= '0;
         r_neg_q   <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
         r_is_div  <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dvsr    <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (InValid) begin
                  r_cnt     <= '0;
                  r_divzero <= 1'b0;
                  r_illegal <= 1'b0;
                  if (w_is_mult) begin
                     r_state <= BUSY;
                     r_mcand <= w_mag_b;
                     r_prod  <= {{WIDTH{1'b0}}, w_mag_a};
                     r_neg_q <= w_signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_MULTICYCLE_DIV_EN
                     r_is_div <= 1'b0;
                  end else if (w_is_div) begin
                     if (B == '0) begin
                        r_state   <= DONE;
                        r_valid   <= 1'b1;
                        r_lo      <= '1;
                        r_hi      <= A;
                        r_result  <= '1;
                        r_zero    <= 1'b0;
                        r_divzero <= 1'b1;
                     end else begin
                        r_state  <= BUSY;
                        r_is_div <= 1'b1;
                        r_dvsr   <= w_mag_b;
                        r_quo    <= w_mag_a;
                        r_rem    <= '0;
                        r_neg_q  <= w_signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r  <= w_signed_op && A[WIDTH-1];
                     end
`endif
                  end else begin
                     r_state   <= DONE;
                     r_valid   <= 1'b1;
                     r_result  <= w_single;
                     r_zero    <= (w_single == '0);
                     r_illegal <= !w_legal;
                  end
               end
            end
            BUSY: begin
               r_cnt  <= r_cnt + CW'(1);
               r_prod <= w_prod_nxt;
`ifdef ALU_MULTICYCLE_DIV_EN
               r_rem  <= w_rem_nxt;
               r_quo  <= w_quo_nxt;
`endif
               if (w_last) begin
                  r_state  <= DONE;
                  r_valid  <= 1'b1;
                  r_hi     <= w_fin_hi;
                  r_lo     <= w_fin_lo;
                  r_result <= w_fin_lo;
                  r_zero   <= (w_fin_lo == '0);
               end
            end
            DONE: begin
               if (OutReady) begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
